// File: rtl/clk_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// clk_pkg: state codes, display selects and time constants for the alarm clock.
// Revision: 1.0
//------------------------------------------------------------------------------
package clk_pkg;

   localparam int BCD_W = 24;
   localparam int CNT_W = 9;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TIME_SET  = 3'd1,
      ST_ALARM_SET = 3'd2,
      ST_RUN       = 3'd3,
      ST_RING      = 3'd4,
      ST_SNOOZE    = 3'd5
   } state_e;

   localparam logic [1:0] DISP_CLOCK = 2'd0;
   localparam logic [1:0] DISP_TSET  = 2'd1;
   localparam logic [1:0] DISP_ASET  = 2'd2;

   localparam logic [BCD_W-1:0] ALARM_DISABLED = 24'hFFFFFF;

   // Second counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 9'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/buzz_tone_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// buzz_tone_gen: square-wave tone, half-period TONE_DIV clks, low and reset while disabled.
// Revision: 1.0
//------------------------------------------------------------------------------
module buzz_tone_gen #(
   parameter int TONE_DIV = 25000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic tone_o
);

   localparam int CW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TONE_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          tone_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (!en_i) begin
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (cnt_q == LAST) begin
         cnt_q  <= '0;
         tone_q <= ~tone_q;
      end else begin
         cnt_q  <= cnt_q + 1'b1;
      end
   end

   assign tone_o = tone_q;

endmodule
`default_nettype wire

// File: rtl/alarm_mode_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// alarm_mode_ctrl: alarm clock mode FSM, alarm match and buzzer; SNOOZE_EN adds snooze.
// Revision: 1.0
//------------------------------------------------------------------------------
module alarm_mode_ctrl
   import clk_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int TONE_DIV   = 25000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode_key,
   input  logic             ack_key,
   input  logic             time_ready,
   input  logic             alarm_ready,
   input  logic             sec_tick,
   input  logic [BCD_W-1:0] cur_time,
   input  logic [BCD_W-1:0] alarm_val,
   output logic             time_set_start,
   output logic             alarm_set_start,
   output logic             run_en,
   output logic [1:0]       disp_sel,
   output logic             buzzer,
   output logic [2:0]       state_o
);

   localparam logic [CNT_W-1:0] RING_LIM = CNT_W'(RING_SEC);

   state_e           state_q;
   logic [BCD_W-1:0] time_q;
   logic             time_rdy_q;
   logic             alarm_rdy_q;
   logic [CNT_W-1:0] ring_cnt_q;
   logic             tset_start_q;
   logic             aset_start_q;
   logic             run_en_q;
   logic [1:0]       disp_sel_q;

   logic [CNT_W-1:0] ring_cnt_d;
   logic             alarm_hit;
   logic             time_rise;
   logic             alarm_rise;
   logic             ring_done;

   // Comparing against last cycle's time makes the match a single-cycle event.
   assign alarm_hit  = (cur_time == alarm_val) && (alarm_val != ALARM_DISABLED) &&
                       (cur_time != time_q);
   assign time_rise  = time_ready  && !time_rdy_q;
   assign alarm_rise = alarm_ready && !alarm_rdy_q;
   assign ring_cnt_d = sat_inc(ring_cnt_q);
   assign ring_done  = sec_tick && (ring_cnt_d >= RING_LIM);

`ifdef SNOOZE_EN
   localparam logic [CNT_W-1:0] SNZ_LIM = CNT_W'(SNOOZE_SEC);

   logic [CNT_W-1:0] snz_cnt_q;
   logic [CNT_W-1:0] snz_cnt_d;
   logic             snz_done;

   assign snz_cnt_d = sat_inc(snz_cnt_q);
   assign snz_done  = sec_tick && (snz_cnt_d >= SNZ_LIM);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         time_q       <= '0;
         time_rdy_q   <= 1'b0;
         alarm_rdy_q  <= 1'b0;
         ring_cnt_q   <= '0;
         tset_start_q <= 1'b0;
         aset_start_q <= 1'b0;
         run_en_q     <= 1'b0;
         disp_sel_q   <= DISP_CLOCK;
`ifdef SNOOZE_EN
         snz_cnt_q    <= '0;
`endif
      end else begin
         time_q       <= cur_time;
         time_rdy_q   <= time_ready;
         alarm_rdy_q  <= alarm_ready;
         tset_start_q <= 1'b0;
         aset_start_q <= 1'b0;

         // Mode-derived outputs follow the current state one cycle later.
         case (state_q)
            ST_TIME_SET: begin
               run_en_q   <= 1'b0;
               disp_sel_q <= DISP_TSET;
            end
            ST_ALARM_SET: begin
               run_en_q   <= 1'b1;
               disp_sel_q <= DISP_ASET;
            end
            ST_RUN, ST_RING: begin
               run_en_q   <= 1'b1;
               disp_sel_q <= DISP_CLOCK;
            end
`ifdef SNOOZE_EN
            ST_SNOOZE: begin
               run_en_q   <= 1'b1;
               disp_sel_q <= DISP_CLOCK;
            end
`endif
            default: begin
               run_en_q   <= 1'b0;
               disp_sel_q <= DISP_CLOCK;
            end
         endcase

         case (state_q)
            ST_IDLE: begin
               if (mode_key) begin
                  state_q      <= ST_TIME_SET;
                  tset_start_q <= 1'b1;
               end
            end
            ST_TIME_SET: begin
               if (time_rise) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (alarm_hit) begin
                  state_q    <= ST_RING;
                  ring_cnt_q <= '0;
               end else if (mode_key) begin
                  state_q      <= ST_ALARM_SET;
                  aset_start_q <= 1'b1;
               end
            end
            ST_ALARM_SET: begin
               if (alarm_rise) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RING: begin
               if (sec_tick) begin
                  ring_cnt_q <= ring_cnt_d;
               end
               if (ack_key || ring_done) begin
                  state_q <= ST_RUN;
`ifdef SNOOZE_EN
               end else if (mode_key) begin
                  state_q   <= ST_SNOOZE;
                  snz_cnt_q <= '0;
`endif
               end
            end
`ifdef SNOOZE_EN
            ST_SNOOZE: begin
               if (sec_tick) begin
                  snz_cnt_q <= snz_cnt_d;
               end
               if (ack_key) begin
                  state_q <= ST_RUN;
               end else if (snz_done) begin
                  state_q    <= ST_RING;
                  ring_cnt_q <= '0;
               end
            end
`endif
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   buzz_tone_gen #(
      .TONE_DIV (TONE_DIV)
   ) u_buzz (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (state_q == ST_RING),
      .tone_o (buzzer)
   );

   assign time_set_start  = tset_start_q;
   assign alarm_set_start = aset_start_q;
   assign run_en          = run_en_q;
   assign disp_sel        = disp_sel_q;
   assign state_o         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_mode_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_alarm_mode_ctrl: scoreboard bench for the alarm clock mode controller.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_alarm_mode_ctrl;

   localparam int RING_SEC   = 3;
   localparam int SNOOZE_SEC = 2;
   localparam int TONE_DIV   = 4;

   localparam int SIG_STATE = 0;
   localparam int SIG_TSS   = 1;
   localparam int SIG_ASS   = 2;
   localparam int SIG_RUN   = 3;
   localparam int SIG_DISP  = 4;
   localparam int SIG_BUZZ  = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mode_key = 1'b0;
   logic        ack_key = 1'b0;
   logic        time_ready = 1'b0;
   logic        alarm_ready = 1'b0;
   logic        sec_tick = 1'b0;
   logic [23:0] cur_time = 24'h000000;
   logic [23:0] alarm_val = 24'hFFFFFF;
   logic        time_set_start;
   logic        alarm_set_start;
   logic        run_en;
   logic [1:0]  disp_sel;
   logic        buzzer;
   logic [2:0]  state_o;

   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alarm_mode_ctrl #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_SEC (SNOOZE_SEC),
      .TONE_DIV   (TONE_DIV)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mode_key        (mode_key),
      .ack_key         (ack_key),
      .time_ready      (time_ready),
      .alarm_ready     (alarm_ready),
      .sec_tick        (sec_tick),
      .cur_time        (cur_time),
      .alarm_val       (alarm_val),
      .time_set_start  (time_set_start),
      .alarm_set_start (alarm_set_start),
      .run_en          (run_en),
      .disp_sel        (disp_sel),
      .buzzer          (buzzer),
      .state_o         (state_o)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sig);
      case (sig)
         SIG_STATE: return {29'd0, state_o};
         SIG_TSS:   return {31'd0, time_set_start};
         SIG_ASS:   return {31'd0, alarm_set_start};
         SIG_RUN:   return {31'd0, run_en};
         SIG_DISP:  return {30'd0, disp_sel};
         default:   return {31'd0, buzzer};
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic expect_all_zero(input string tag);
      expect_val({tag, "_state"}, SIG_STATE, 0);
      expect_val({tag, "_tss"},   SIG_TSS,   0);
      expect_val({tag, "_ass"},   SIG_ASS,   0);
      expect_val({tag, "_run"},   SIG_RUN,   0);
      expect_val({tag, "_disp"},  SIG_DISP,  0);
      expect_val({tag, "_buzz"},  SIG_BUZZ,  0);
   endtask

   task automatic sb_check();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, observe(e.sig), e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic key_tick(input logic m, input logic a, input logic s);
      mode_key = m;
      ack_key  = a;
      sec_tick = s;
      tick();
      mode_key = 1'b0;
      ack_key  = 1'b0;
      sec_tick = 1'b0;
   endtask

   // From RUN with alarm_val = 000005: step into the alarm second.
   task automatic enter_ring(input string tag);
      cur_time = 24'h000006;
      tick();
      cur_time = 24'h000005;
      expect_val({tag, "_ring"}, SIG_STATE, 4);
      tick();
      sb_check();
   endtask

   initial begin
      // Reset
      #12;
      expect_all_zero("rst");
      sb_check();
      #1 rst_n = 1'b1;
      tick();

      // 1: IDLE -> TIME_SET -> RUN
      expect_val("t1_state_tset", SIG_STATE, 1);
      expect_val("t1_tss_hi", SIG_TSS, 1);
      key_tick(1'b1, 1'b0, 1'b0);
      sb_check();
      expect_val("t1_tss_lo", SIG_TSS, 0);
      expect_val("t1_disp_tset", SIG_DISP, 1);
      expect_val("t1_run_off", SIG_RUN, 0);
      key_tick(1'b1, 1'b0, 1'b0);
      sb_check();
      expect_val("t1_mode_ignored", SIG_STATE, 1);
      expect_val("t1_tss_none", SIG_TSS, 0);
      tick();
      sb_check();
      time_ready = 1'b1;
      expect_val("t1_state_run", SIG_STATE, 3);
      tick();
      sb_check();
      expect_val("t1_run_on", SIG_RUN, 1);
      expect_val("t1_disp_clk", SIG_DISP, 0);
      tick();
      sb_check();

      // 2: match -> RING, tone period 2*TONE_DIV, ack, no re-ring
      alarm_val = 24'h000005;
      cur_time  = 24'h000004;
      expect_val("t2_pre", SIG_STATE, 3);
      tick();
      sb_check();
      cur_time = 24'h000005;
      expect_val("t2_ring", SIG_STATE, 4);
      expect_val("t2_buzz0", SIG_BUZZ, 0);
      tick();
      sb_check();
      for (int k = 1; k <= 12; k++) begin
         expect_val($sformatf("t2_buzz%0d", k), SIG_BUZZ, (k / TONE_DIV) % 2);
         tick();
         sb_check();
      end
      expect_val("t2_ack_state", SIG_STATE, 3);
      expect_val("t2_buzz13", SIG_BUZZ, (13 / TONE_DIV) % 2);
      key_tick(1'b0, 1'b1, 1'b0);
      sb_check();
      expect_val("t2_buzz_off", SIG_BUZZ, 0);
      tick();
      sb_check();
      for (int k = 0; k < 3; k++) begin
         expect_val($sformatf("t2_no_rering%0d", k), SIG_STATE, 3);
         tick();
         sb_check();
      end

      // 3: ring timeout after RING_SEC ticks
      enter_ring("t3");
      for (int k = 1; k <= RING_SEC; k++) begin
         expect_val($sformatf("t3_tick%0d", k), SIG_STATE, (k < RING_SEC) ? 4 : 3);
         key_tick(1'b0, 1'b0, 1'b1);
         sb_check();
      end
      expect_val("t3_buzz_off", SIG_BUZZ, 0);
      expect_val("t3_run_en", SIG_RUN, 1);
      tick();
      sb_check();

      // 4: snooze
      enter_ring("t4");
`ifdef SNOOZE_EN
      expect_val("t4_snooze", SIG_STATE, 5);
      key_tick(1'b1, 1'b0, 1'b0);
      sb_check();
      expect_val("t4_snz_buzz", SIG_BUZZ, 0);
      expect_val("t4_snz_run", SIG_RUN, 1);
      tick();
      sb_check();
      for (int k = 1; k <= SNOOZE_SEC; k++) begin
         expect_val($sformatf("t4_snz_tick%0d", k), SIG_STATE, (k < SNOOZE_SEC) ? 5 : 4);
         key_tick(1'b0, 1'b0, 1'b1);
         sb_check();
      end
`else
      expect_val("t4_no_snooze", SIG_STATE, 4);
      key_tick(1'b1, 1'b0, 1'b0);
      sb_check();
`endif
      expect_val("t4_ack", SIG_STATE, 3);
      key_tick(1'b0, 1'b1, 1'b0);
      sb_check();

      // 5: ack beats mode; match beats mode; disabled alarm never rings
      enter_ring("t5");
      expect_val("t5_ack_mode", SIG_STATE, 3);
      key_tick(1'b1, 1'b1, 1'b0);
      sb_check();
      cur_time = 24'h000006;
      tick();
      cur_time = 24'h000005;
      expect_val("t5_match_wins", SIG_STATE, 4);
      expect_val("t5_no_aset_pulse", SIG_ASS, 0);
      key_tick(1'b1, 1'b0, 1'b0);
      sb_check();
      key_tick(1'b0, 1'b1, 1'b0);
      alarm_val = 24'hFFFFFF;
      cur_time  = 24'h000000;
      tick();
      cur_time = 24'hFFFFFF;
      expect_val("t5_disabled", SIG_STATE, 3);
      tick();
      sb_check();
      alarm_val = 24'h000005;
      cur_time  = 24'h000000;
      tick();

      // 6: ALARM_SET, lost match, async reset mid-ring
      expect_val("t6_aset", SIG_STATE, 2);
      expect_val("t6_ass_hi", SIG_ASS, 1);
      key_tick(1'b1, 1'b0, 1'b0);
      sb_check();
      expect_val("t6_ass_lo", SIG_ASS, 0);
      expect_val("t6_disp_aset", SIG_DISP, 2);
      expect_val("t6_run_on", SIG_RUN, 1);
      tick();
      sb_check();
      cur_time = 24'h000006;
      tick();
      cur_time = 24'h000005;
      expect_val("t6_match_ignored", SIG_STATE, 2);
      tick();
      sb_check();
      alarm_ready = 1'b1;
      expect_val("t6_back_run", SIG_STATE, 3);
      tick();
      sb_check();
      expect_val("t6_match_lost", SIG_STATE, 3);
      expect_val("t6_disp_clk", SIG_DISP, 0);
      tick();
      sb_check();
      enter_ring("t6");
      for (int k = 1; k <= TONE_DIV; k++) begin
         expect_val($sformatf("t6_buzz%0d", k), SIG_BUZZ, (k / TONE_DIV) % 2);
         tick();
         sb_check();
      end
      #2 rst_n = 1'b0;
      #1;
      expect_all_zero("t6_async_rst");
      sb_check();
      #3 rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
